// File: rtl/window_sync_ctrl.sv
// window_sync_ctrl: arms on software request, aligns to the external sync,
// emits a periodic one-cycle sync to the window datapath and tracks lock.
//   user_clk   : datapath clock, rising edge
//   user_rst_n : async active-low reset
//   arm        : software arm level; rising edge arms, low level disarms
//   period     : frame length minus 1; sampled on the arm rising edge
//   sync_in    : external sync level, already in user_clk domain
//   sync_out   : one-cycle sync pulse to the window datapath
//   locked     : alignment confirmed (LOCK_N consecutive aligned syncs)
//   status     : {state, locked, sync_in, 4'b0, good_cnt, err_cnt}
module window_sync_ctrl #(
  parameter int PERIOD_W = 24,
  parameter int LOCK_N   = 4
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic                arm,
  input  logic [PERIOD_W-1:0] period,
  input  logic                sync_in,
  output logic                sync_out,
  output logic                locked,
  output logic [31:0]         status
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    BAD   = 2'd3
  } state_t;

  localparam logic [3:0]  LOCK_V = 4'(LOCK_N);
  localparam logic [11:0] CNT_MAX = 12'hFFF;

  state_t              state_q;
  state_t              state_nx;
  logic [PERIOD_W-1:0] phase_q;
  logic [PERIOD_W-1:0] phase_nx;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_nx;
  logic [11:0]         good_q;
  logic [11:0]         good_nx;
  logic [11:0]         err_q;
  logic [11:0]         err_nx;
  logic [3:0]          run_q;
  logic [3:0]          run_nx;
  logic                pulse_nx;
  logic                sync_d;
  logic                arm_d;
  logic                sync_edge;
  logic                arm_edge;
  logic                at_end;

  assign sync_edge = sync_in & ~sync_d;
  assign arm_edge  = arm & ~arm_d;
  assign at_end    = (phase_q == period_q);

  always_comb begin
    state_nx  = state_q;
    phase_nx  = phase_q;
    period_nx = period_q;
    good_nx   = good_q;
    err_nx    = err_q;
    run_nx    = run_q;
    pulse_nx  = 1'b0;
    case (state_q)
      IDLE: begin
        // a sync edge in the arming cycle is deliberately ignored
        if (arm_edge) begin
          period_nx = period;
          good_nx   = '0;
          err_nx    = '0;
          run_nx    = '0;
          phase_nx  = '0;
          state_nx  = ARMED;
        end
      end
      ARMED: begin
        if (!arm) begin
          state_nx = IDLE;
        end else if (sync_edge) begin
          state_nx = RUN;
          phase_nx = '0;
          pulse_nx = 1'b1;
        end
      end
      RUN: begin
        if (!arm) begin
          state_nx = IDLE;
        end else begin
          // frame wrap and resync share one pulse
          if (at_end || sync_edge) begin
            phase_nx = '0;
            pulse_nx = 1'b1;
          end else begin
            phase_nx = phase_q + 1'b1;
          end
          if (sync_edge && at_end) begin
            if (good_q != CNT_MAX)
              good_nx = good_q + 12'd1;
            if (run_q < LOCK_V)
              run_nx = run_q + 4'd1;
          end else if (sync_edge) begin
            if (err_q != CNT_MAX)
              err_nx = err_q + 12'd1;
            run_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      period_q <= '0;
      good_q   <= '0;
      err_q    <= '0;
      run_q    <= '0;
      sync_d   <= 1'b0;
      arm_d    <= 1'b1;
      sync_out <= 1'b0;
      locked   <= 1'b0;
      status   <= '0;
    end else begin
      state_q  <= state_nx;
      phase_q  <= phase_nx;
      period_q <= period_nx;
      good_q   <= good_nx;
      err_q    <= err_nx;
      run_q    <= run_nx;
      sync_d   <= sync_in;
      arm_d    <= arm;
      sync_out <= pulse_nx;
      locked   <= (state_nx == RUN) && (run_nx >= LOCK_V);
      status   <= {state_q, locked, sync_in, 4'b0, good_q, err_q};
    end
  end

endmodule

// File: tb/tb_window_sync_ctrl.sv
// tb_window_sync_ctrl: directed checks of arming, framing, lock,
// resync, saturation, period 0, disarm and async reset.
module tb_window_sync_ctrl;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic [23:0] period;
  logic        sync_in;
  logic        sync_out;
  logic        locked;
  logic [31:0] status;

  int tests;
  int fails;
  int bad;

  window_sync_ctrl #(.PERIOD_W(24), .LOCK_N(4)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .arm        (arm),
    .period     (period),
    .sync_in    (sync_in),
    .sync_out   (sync_out),
    .locked     (locked),
    .status     (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sync_in high for exactly one sampled edge; returns #1 after that edge
  task automatic pulse_sync();
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    arm     = 1'b1;
    period  = 24'd99;
    sync_in = 1'b0;
    step(2);
    chk("rst_status", status, 32'h0);
    chk("rst_sync_out", {31'b0, sync_out}, 32'h0);
    rst_n = 1'b1;
    step(3);
    chk("arm_held_idle", status, 32'h0);

    arm = 1'b0;
    step(1);
    arm = 1'b1;
    step(1);
    step(1);
    chk("armed_status", status, 32'h4000_0000);

    pulse_sync();
    chk("first_sync_out", {31'b0, sync_out}, 32'h1);
    step(99);
    chk("phase99_no_pulse", {31'b0, sync_out}, 32'h0);
    step(1);
    chk("frame_pulse", {31'b0, sync_out}, 32'h1);
    chk("run_state", {30'b0, status[31:30]}, 32'h2);

    for (int i = 0; i < 4; i++) begin
      step(99);
      if (i == 3)
        chk("unlocked_pre4", {31'b0, locked}, 32'h0);
      pulse_sync();
      chk("aligned_pulse", {31'b0, sync_out}, 32'h1);
    end
    chk("locked_after4", {31'b0, locked}, 32'h1);
    step(1);
    chk("lock_status", status, 32'hA000_4000);
    chk("single_pulse", {31'b0, sync_out}, 32'h0);

    step(36);
    pulse_sync();
    chk("resync_pulse", {31'b0, sync_out}, 32'h1);
    chk("unlock_misalign", {31'b0, locked}, 32'h0);
    step(1);
    chk("err_status", status, 32'h8000_4001);
    step(98);
    chk("new_frame_gap", {31'b0, sync_out}, 32'h0);
    step(1);
    chk("new_frame_pulse", {31'b0, sync_out}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(99);
      pulse_sync();
    end
    chk("relocked", {31'b0, locked}, 32'h1);

    step(50);
    arm = 1'b0;
    step(1);
    chk("disarm_sync_out", {31'b0, sync_out}, 32'h0);
    chk("disarm_locked", {31'b0, locked}, 32'h0);
    step(1);
    chk("disarm_status", status, 32'h0000_8001);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (sync_out) bad++;
    end
    chk("idle_quiet", bad, 32'h0);

    arm = 1'b1;
    step(1);
    pulse_sync();
    for (int i = 0; i < 5000; i++) begin
      step(1);
      pulse_sync();
    end
    step(1);
    chk("err_saturate", status, 32'h8000_0FFF);

    arm = 1'b0;
    step(1);
    period  = 24'd0;
    arm     = 1'b1;
    sync_in = 1'b1;
    step(1);
    chk("arm_sync_same", {31'b0, sync_out}, 32'h0);
    step(1);
    chk("arm_sync_armed", {30'b0, status[31:30]}, 32'h1);
    sync_in = 1'b0;
    step(1);
    pulse_sync();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!sync_out) bad++;
      step(1);
    end
    chk("p0_continuous", bad, 32'h0);
    for (int i = 0; i < 4; i++) begin
      pulse_sync();
      step(1);
    end
    chk("p0_locked", {31'b0, locked}, 32'h1);
    step(1);
    chk("p0_good", {20'b0, status[23:12]}, 32'h4);

    rst_n = 1'b0;
    #1;
    chk("async_sync_out", {31'b0, sync_out}, 32'h0);
    chk("async_locked", {31'b0, locked}, 32'h0);
    chk("async_status", status, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
